// File: rtl/tiny_cpu_pkg.sv
// Shared constants for the tiny accumulator CPU: instruction field widths
// and the 4-bit opcode encoding.
package tiny_cpu_pkg;

  localparam int unsigned INSTR_W  = 8;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned IMM_W    = 4;
  localparam int unsigned PC_W     = 4;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_LDIN = 4'h7,
    OP_OUT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JNZ  = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_LDHI = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Immediates are unsigned and always widened with zeros into the data path.
  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/tiny_cpu_rom.sv
// Hard-wired 16-word program store: counts 5 down to 0 on the output port,
// then emits the input port value plus one and halts.
module tiny_cpu_rom
  import tiny_cpu_pkg::*;
(
  input  logic [PC_W-1:0]    addr,
  output logic [INSTR_W-1:0] instr
);

  always_comb begin
    instr = 8'h00;
    case (addr)
      4'd0:    instr = 8'h15;
      4'd1:    instr = 8'h80;
      4'd2:    instr = 8'h31;
      4'd3:    instr = 8'hB1;
      4'd4:    instr = 8'h80;
      4'd5:    instr = 8'h70;
      4'd6:    instr = 8'h21;
      4'd7:    instr = 8'h80;
      4'd8:    instr = 8'hF0;
      default: instr = 8'h00;
    endcase
  end

endmodule

// File: rtl/tiny_cpu.sv
// Single-cycle 8-bit accumulator CPU: fetches from the internal ROM and
// executes one instruction per rising clock edge until HALT.
module tiny_cpu
  import tiny_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ui_in,
  output logic [DATA_W-1:0] uo_out
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               halt_q, halt_d;
  logic [INSTR_W-1:0] instr;
  logic [IMM_W-1:0]   imm;
  opcode_e            opcode;

  tiny_cpu_rom u_rom (
    .addr  (pc_q),
    .instr (instr)
  );

  assign opcode = opcode_e'(instr[INSTR_W-1 -: OPCODE_W]);
  assign imm    = instr[IMM_W-1:0];

  always_comb begin
    pc_d   = pc_q + 4'd1;
    acc_d  = acc_q;
    out_d  = out_q;
    halt_d = halt_q;
    if (halt_q) begin
      pc_d = pc_q;
    end else begin
      case (opcode)
        OP_NOP:  ;
        OP_LDI:  acc_d = zext_imm(imm);
        OP_ADDI: acc_d = acc_q + zext_imm(imm);
        OP_SUBI: acc_d = acc_q - zext_imm(imm);
        OP_AND:  acc_d = acc_q & ui_in;
        OP_OR:   acc_d = acc_q | ui_in;
        OP_XOR:  acc_d = acc_q ^ ui_in;
        OP_LDIN: acc_d = ui_in;
        OP_OUT:  out_d = acc_q;
        OP_JMP:  pc_d = imm;
        OP_JZ:   if (acc_q == 8'h00) pc_d = imm;
        OP_JNZ:  if (acc_q != 8'h00) pc_d = imm;
        OP_SHL:  acc_d = {acc_q[DATA_W-2:0], 1'b0};
        OP_SHR:  acc_d = {1'b0, acc_q[DATA_W-1:1]};
        OP_LDHI: acc_d = {imm, acc_q[3:0]};
        OP_HALT: begin
          halt_d = 1'b1;
          pc_d   = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      halt_q <= halt_d;
    end
  end

  assign uo_out = out_q;

endmodule

// File: tb/tb_tiny_cpu.sv
// Directed self-checking bench for tiny_cpu: reset, countdown sequence,
// input path, wraparound, mid-run reset and halt freeze.
module tb_tiny_cpu;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int check_count = 0;
  int fail_count  = 0;

  tiny_cpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=0x%02h required=0x%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    ui_in = value;
  endtask

  // Holds reset for two cycles, then releases it on a falling edge so the
  // next rising edge is edge 1.
  task automatic resetCpu();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] countdownValue(input int n);
    if (n < 2)  return 8'h00;
    if (n < 5)  return 8'h05;
    if (n < 8)  return 8'h04;
    if (n < 11) return 8'h03;
    if (n < 14) return 8'h02;
    if (n < 17) return 8'h01;
    if (n < 20) return 8'h00;
    return 8'h01;
  endfunction

  logic [7:0] held;

  initial begin
    rst_n = 1'b1;
    applyStimulus(8'h00);

    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_uo_out", uo_out, 8'h00);
    checkOutput("reset_pc", {4'h0, dut.pc_q}, 8'h00);
    checkOutput("reset_acc", dut.acc_q, 8'h00);
    rst_n = 1'b1;

    // Countdown with ui_in = 0, extended well past the halt
    for (int n = 1; n <= 45; n++) begin
      stepEdge();
      checkOutput($sformatf("countdown_e%0d", n), uo_out, countdownValue(n));
      if (n == 20) checkOutput("halt_clear_e20", {7'd0, dut.halt_q}, 8'h00);
      if (n == 21) checkOutput("halt_set_e21", {7'd0, dut.halt_q}, 8'h01);
    end
    checkOutput("halt_pc", {4'h0, dut.pc_q}, 8'h08);

    // Input path: 0x41 throughout
    applyStimulus(8'h41);
    resetCpu();
    for (int n = 1; n <= 25; n++) begin
      stepEdge();
      if (n == 19) checkOutput("input_e19", uo_out, 8'h00);
      if (n >= 20) checkOutput($sformatf("input_e%0d", n), uo_out, 8'h42);
    end

    // Halt freeze: random ui_in must not disturb the frozen state
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      stepEdge();
      checkOutput($sformatf("freeze_uo_%0d", i), uo_out, 8'h42);
    end
    checkOutput("freeze_pc", {4'h0, dut.pc_q}, 8'h08);
    checkOutput("freeze_acc", dut.acc_q, 8'h42);

    // Wrap: 0xFF + 1 = 0x00; ui_in changes after edge 18 to prove the sample point
    applyStimulus(8'hFF);
    resetCpu();
    for (int n = 1; n <= 22; n++) begin
      stepEdge();
      if (n == 18) applyStimulus(8'h10);
      if (n == 17) checkOutput("wrap_e17", uo_out, 8'h00);
      if (n >= 20) checkOutput($sformatf("wrap_e%0d", n), uo_out, 8'h00);
    end
    checkOutput("wrap_acc", dut.acc_q, 8'h00);

    // Mid-run reset after edge 9, when uo_out is 0x03
    applyStimulus(8'h00);
    resetCpu();
    for (int n = 1; n <= 9; n++) stepEdge();
    checkOutput("midrun_before", uo_out, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_async_uo", uo_out, 8'h00);
    checkOutput("midrun_async_pc", {4'h0, dut.pc_q}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      stepEdge();
      checkOutput($sformatf("restart_e%0d", n), uo_out, countdownValue(n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/tiny_cpu.md
# tiny_cpu

Minimal 8-bit accumulator CPU with an internal 16-word hard-wired program ROM, one 8-bit input port and one registered 8-bit output port. Executes one instruction per clock, no pipeline. Top-level compute block of the chip; `ui_in` comes straight from the pads and `uo_out` drives them.

## Interface
- No parameters; ROM depth 16, data width 8, both fixed.
- `clk`  in  1  single system clock, all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ui_in`  in  8  external data operand for LDIN/AND/OR/XOR.
- `uo_out`  out  8  output register, written only by OUT.

## Operation
- State: PC (4 bit), ACC (8 bit), OUT (8 bit), HALT flag (1 bit).
- Fetch: instruction = ROM[PC], combinational; opcode = instr[7:4], imm = instr[3:0].
- Opcodes; PC <= PC+1 (mod 16) unless stated:
  - 0 NOP
  - 1 LDI: ACC <= {4'h0, imm}
  - 2 ADDI: ACC <= ACC + imm
  - 3 SUBI: ACC <= ACC - imm
  - 4 AND: ACC <= ACC & ui_in
  - 5 OR: ACC <= ACC | ui_in
  - 6 XOR: ACC <= ACC ^ ui_in
  - 7 LDIN: ACC <= ui_in
  - 8 OUT: OUT <= ACC
  - 9 JMP: PC <= imm
  - A JZ: PC <= imm if ACC == 0
  - B JNZ: PC <= imm if ACC != 0
  - C SHL: ACC <= ACC << 1, zero fill
  - D SHR: ACC <= ACC >> 1, zero fill
  - E LDHI: ACC[7:4] <= imm, ACC[3:0] unchanged
  - F HALT: HALT <= 1, PC unchanged
- Arithmetic: 8-bit, wraps mod 256; no carry or flag registers. The JZ/JNZ test uses the ACC value before the edge.
- While HALT = 1: PC, ACC and OUT frozen; only reset clears it.
- PC wraps 15 -> 0.
- ROM contents, address: value:
  - 0: 0x15 LDI 5
  - 1: 0x80 OUT
  - 2: 0x31 SUBI 1
  - 3: 0xB1 JNZ 1
  - 4: 0x80 OUT
  - 5: 0x70 LDIN
  - 6: 0x21 ADDI 1
  - 7: 0x80 OUT
  - 8: 0xF0 HALT
  - 9-15: 0x00 NOP

## Timing
- Reset (`rst_n` low, async): PC = 0, ACC = 0x00, OUT = 0x00, HALT = 0; `uo_out` = 0x00 immediately. Reset asserted mid-program restarts from address 0.
- One instruction completes per rising edge after reset release; the first edge executes ROM[0].
- `uo_out` is the registered OUT value and changes only on the edge that executes OUT.
- `ui_in` is sampled on the executing edge; no synchronizer inside the block.
- Program reference sequence (edge count after release, `ui_in` = 0x00):
  - `uo_out` = 0x05 at edge 2, 0x04 at edge 5, 0x03 at 8, 0x02 at 11, 0x01 at 14, 0x00 at 17, 0x01 at 20.
  - HALT at edge 21, then static.
- Final `uo_out` = `ui_in` + 1, with `ui_in` sampled at edge 18.

## Structure
- Package `tiny_cpu_pkg`: 4-bit opcode constants (OP_NOP … OP_HALT), instruction field widths.
- Sub-module `tiny_cpu_rom`: 4-bit address in, 8-bit instruction out, combinational case table.
- Top holds the PC/ACC/OUT/HALT registers and the execute/next-PC logic.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles -> `uo_out` = 0x00; PC = 0 and ACC = 0 internally.
- Countdown: `ui_in` = 0x00, release reset -> `uo_out` steps 05, 04, 03, 02, 01, 00, 01 at edges 2/5/8/11/14/17/20, then stays 0x01 for 20+ cycles.
- Input path: `ui_in` = 0x41 throughout -> final `uo_out` = 0x42 after edge 20, unchanged afterward.
- Wrap: `ui_in` = 0xFF -> final `uo_out` = 0x00 (ADDI wraps mod 256).
- Mid-run reset: pulse `rst_n` low at edge 9, release -> `uo_out` = 0x00 at once, sequence restarts with 0x05 at edge 2.
- Halt freeze: after edge 21, toggle `ui_in` randomly for 10 cycles -> `uo_out` unchanged.
